// File: rtl/div_arb_pkg.sv
// rtl/div_arb_pkg.sv - shared types and widths for the divider arbiter
package div_arb_pkg;

    localparam int DIV_W   = 32;
    localparam int FLAGS_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at ptr
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    int k;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        k     = 0;
        // Walk ptr, ptr+1, ... wrapping at N; first requester found wins.
        for (int i = 0; i < N; i++) begin
            k = int'(ptr) + i;
            if (k >= N) begin
                k = k - N;
            end
            if (!any && req[IW'(k)]) begin
                any            = 1'b1;
                grant[IW'(k)]  = 1'b1;
                idx            = IW'(k);
            end
        end
    end

endmodule

// File: rtl/div_arbiter.sv
// rtl/div_arbiter.sv - round-robin sharing of one divider between NREQ requesters
module div_arbiter
    import div_arb_pkg::*;
#(
    parameter  int NREQ = 2,
    parameter  int DW   = DIV_W,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [NREQ-1:0]      i_req_valid,
    output logic [NREQ-1:0]      o_req_ready,
    input  logic [NREQ-1:0]      i_req_signed,
    input  logic [NREQ*DW-1:0]   i_req_num,
    input  logic [NREQ*DW-1:0]   i_req_den,
    output logic [NREQ-1:0]      o_rsp_valid,
    input  logic [NREQ-1:0]      i_rsp_ready,
    output logic [DW-1:0]        o_rsp_quotient,
    output logic                 o_rsp_err,
    output logic [FLAGS_W-1:0]   o_rsp_flags,
    output logic                 o_div_wr,
    output logic                 o_div_signed,
    output logic [DW-1:0]        o_div_numerator,
    output logic [DW-1:0]        o_div_denominator,
    input  logic                 i_div_busy,
    input  logic                 i_div_valid,
    input  logic                 i_div_err,
    input  logic [DW-1:0]        i_div_quotient,
    input  logic [FLAGS_W-1:0]   i_div_flags,
    output logic [IW-1:0]        o_owner,
    output logic                 o_protocol_err
);

    arb_state_t          state, state_next;
    logic [IW-1:0]       rr_ptr;
    logic [IW-1:0]       owner;
    logic                sgn_r;
    logic [DW-1:0]       num_r;
    logic [DW-1:0]       den_r;
    logic [DW-1:0]       quo_r;
    logic                err_r;
    logic [FLAGS_W-1:0]  flags_r;
    logic                proto_err;

    logic [NREQ-1:0]     pick_grant;
    logic [IW-1:0]       pick_idx;
    logic                pick_any;
    logic                grant_ok;

    rr_arbiter #(.N(NREQ), .IW(IW)) u_rr (
        .req   (i_req_valid),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // Grant depends only on valid bits, pointer and divider busy, never on operands.
    assign grant_ok = (state == IDLE) && pick_any && !i_div_busy;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        o_req_ready = '0;
        o_div_wr    = 1'b0;
        o_rsp_valid = '0;
        case (state)
            IDLE: begin
                if (grant_ok) begin
                    o_req_ready = pick_grant;
                    state_next  = ISSUE;
                end
            end
            ISSUE: begin
                o_div_wr   = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                if (i_div_valid) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                o_rsp_valid[owner] = 1'b1;
                if (i_rsp_ready[owner]) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rr_ptr    <= '0;
            owner     <= '0;
            sgn_r     <= 1'b0;
            num_r     <= '0;
            den_r     <= '0;
            quo_r     <= '0;
            err_r     <= 1'b0;
            flags_r   <= '0;
            proto_err <= 1'b0;
        end else begin
            if (grant_ok) begin
                sgn_r  <= i_req_signed[pick_idx];
                num_r  <= i_req_num[pick_idx*DW +: DW];
                den_r  <= i_req_den[pick_idx*DW +: DW];
                owner  <= pick_idx;
                rr_ptr <= (pick_idx == IW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
            end
            if (i_div_valid) begin
                if (state == WAIT) begin
                    quo_r   <= i_div_quotient;
                    err_r   <= i_div_err;
                    flags_r <= i_div_flags;
                end else begin
                    // A result with no outstanding request means the divider lost sync.
                    proto_err <= 1'b1;
                end
            end
        end
    end

    assign o_div_signed      = sgn_r;
    assign o_div_numerator   = num_r;
    assign o_div_denominator = den_r;
    assign o_rsp_quotient    = quo_r;
    assign o_rsp_err         = err_r;
    assign o_rsp_flags       = flags_r;
    assign o_owner           = owner;
    assign o_protocol_err    = proto_err;

endmodule

// File: tb/tb_div_arbiter.sv
// tb/tb_div_arbiter.sv - scoreboard bench for div_arbiter with a behavioural divider
module tb_div_arbiter;

    localparam int NREQ = 2;
    localparam int DW   = 32;
    localparam int LAT  = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   req_signed;
    logic [NREQ*DW-1:0] req_num;
    logic [NREQ*DW-1:0] req_den;
    logic [NREQ-1:0]   rsp_valid;
    logic [NREQ-1:0]   rsp_ready;
    logic [DW-1:0]     rsp_quotient;
    logic              rsp_err;
    logic [3:0]        rsp_flags;
    logic              div_wr;
    logic              div_signed;
    logic [DW-1:0]     div_numerator;
    logic [DW-1:0]     div_denominator;
    logic              div_busy;
    logic              div_valid;
    logic              div_err;
    logic [DW-1:0]     div_quotient;
    logic [3:0]        div_flags;
    logic              owner;
    logic              protocol_err;

    div_arbiter #(.NREQ(NREQ), .DW(DW)) dut (
        .i_clk             (clk),
        .i_reset           (reset),
        .i_req_valid       (req_valid),
        .o_req_ready       (req_ready),
        .i_req_signed      (req_signed),
        .i_req_num         (req_num),
        .i_req_den         (req_den),
        .o_rsp_valid       (rsp_valid),
        .i_rsp_ready       (rsp_ready),
        .o_rsp_quotient    (rsp_quotient),
        .o_rsp_err         (rsp_err),
        .o_rsp_flags       (rsp_flags),
        .o_div_wr          (div_wr),
        .o_div_signed      (div_signed),
        .o_div_numerator   (div_numerator),
        .o_div_denominator (div_denominator),
        .i_div_busy        (div_busy),
        .i_div_valid       (div_valid),
        .i_div_err         (div_err),
        .i_div_quotient    (div_quotient),
        .i_div_flags       (div_flags),
        .o_owner           (owner),
        .o_protocol_err    (protocol_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  idx;
        logic [31:0] q;
        logic        err;
        logic [3:0]  flags;
    } rsp_t;

    rsp_t rsp_q[$];
    int   grant_q[$];
    int   checks = 0;
    int   errors = 0;
    logic inject = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // Behavioural divider: takes o_div_wr, is busy LAT cycles, pulses valid once.
    initial begin
        int          cnt;
        logic        pend;
        logic        s;
        logic [31:0] n, d, rq;
        logic        re;
        logic [3:0]  rf;
        cnt = 0; pend = 1'b0; s = 1'b0; n = '0; d = '0; rq = '0; re = 1'b0; rf = '0;
        div_busy = 1'b0; div_valid = 1'b0; div_err = 1'b0; div_quotient = '0; div_flags = '0;
        forever begin
            @(posedge clk);
            #1;
            div_valid = 1'b0;
            if (reset) begin
                div_busy = 1'b0;
                cnt      = 0;
                pend     = 1'b0;
            end else begin
                if (cnt != 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        div_busy     = 1'b0;
                        div_valid    = 1'b1;
                        div_quotient = rq;
                        div_err      = re;
                        div_flags    = rf;
                    end
                end
                if (pend) begin
                    if (d == 0) begin
                        rq = '0; re = 1'b1;
                    end else if (s) begin
                        rq = $signed(n) / $signed(d); re = 1'b0;
                    end else begin
                        rq = n / d; re = 1'b0;
                    end
                    rf       = {1'b0, re, rq[31], (rq == 0)};
                    cnt      = LAT;
                    div_busy = 1'b1;
                end
                pend = div_wr;
                if (div_wr) begin
                    s = div_signed; n = div_numerator; d = div_denominator;
                end
                if (inject) begin
                    div_valid    = 1'b1;
                    div_quotient = 32'hdeadbeef;
                    div_err      = 1'b0;
                    div_flags    = 4'hf;
                end
            end
        end
    end

    // Monitor: pops grant and response expectations whenever the DUT hands something over.
    initial begin
        logic prev_acc;
        int   prev_idx;
        int   idx;
        rsp_t e;
        prev_acc = 1'b0;
        prev_idx = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_acc = 1'b0;
            end else begin
                if (req_ready != 0) check("req_ready_onehot", 64'($onehot(req_ready)), 64'd1);
                if (prev_acc || div_wr) check("div_wr_timing", 64'(div_wr), 64'(prev_acc));
                if (prev_acc) check("owner_after_grant", 64'(owner), 64'(prev_idx));
                idx = 0;
                for (int i = 0; i < NREQ; i++) if (req_ready[i]) idx = i;
                prev_acc = |(req_ready & req_valid);
                prev_idx = idx;
                if (prev_acc) begin
                    if (grant_q.size() == 0) fail_now("grant_unexpected");
                    else check("grant_order", 64'(idx), 64'(grant_q.pop_front()));
                end
                if (|(rsp_valid & rsp_ready)) begin
                    check("rsp_valid_onehot", 64'($onehot(rsp_valid)), 64'd1);
                    idx = 0;
                    for (int i = 0; i < NREQ; i++) if (rsp_valid[i]) idx = i;
                    if (rsp_q.size() == 0) begin
                        fail_now("rsp_unexpected");
                    end else begin
                        e = rsp_q.pop_front();
                        check("rsp_idx", 64'(idx), 64'(e.idx));
                        check("rsp_quotient", 64'(rsp_quotient), 64'(e.q));
                        check("rsp_err", 64'(rsp_err), 64'(e.err));
                        check("rsp_flags", 64'(rsp_flags), 64'(e.flags));
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(input int k, input logic s, input logic [31:0] n, input logic [31:0] d);
        req_signed[k]      = s;
        req_num[k*DW +: DW] = n;
        req_den[k*DW +: DW] = d;
    endtask

    task automatic issue(input int k, input logic s, input logic [31:0] n, input logic [31:0] d);
        logic got;
        got = 1'b0;
        set_req(k, s, n, d);
        req_valid[k] = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (req_ready[k]) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) fail_now("accept_timeout");
        step();
        req_valid[k] = 1'b0;
    endtask

    task automatic drain();
        logic done;
        done = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (rsp_q.size() == 0 && grant_q.size() == 0) begin
                done = 1'b1;
                break;
            end
            step();
        end
        if (!done) fail_now("drain_timeout");
        step();
    endtask

    task automatic run_both(input int n);
        int acc;
        acc = 0;
        req_valid = '1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (|(req_ready & req_valid)) acc++;
            if (acc == n) break;
        end
        if (acc != n) fail_now("run_both_timeout");
        step();
        req_valid = '0;
    endtask

    task automatic push_rsp(input int k, input logic [31:0] q, input logic err, input logic [3:0] fl);
        rsp_t r;
        r.idx = 2'(k); r.q = q; r.err = err; r.flags = fl;
        rsp_q.push_back(r);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog_expired");
        $fatal(1);
    end

    initial begin
        reset      = 1'b1;
        req_valid  = '0;
        req_signed = '0;
        req_num    = '0;
        req_den    = '0;
        rsp_ready  = '1;
        step();
        step();
        @(negedge clk);
        check("reset_req_ready", 64'(req_ready), 64'd0);
        check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset_div_wr", 64'(div_wr), 64'd0);
        check("reset_owner", 64'(owner), 64'd0);
        check("reset_protocol_err", 64'(protocol_err), 64'd0);
        check("reset_div_num", 64'(div_numerator), 64'd0);
        step();
        reset = 1'b0;
        step();

        // Single unsigned request.
        grant_q.push_back(0);
        push_rsp(0, 32'd14, 1'b0, 4'b0000);
        issue(0, 1'b0, 32'd100, 32'd7);
        drain();

        // Signed request, then divide by zero.
        grant_q.push_back(1);
        push_rsp(1, 32'hfffffff2, 1'b0, 4'b0010);
        issue(1, 1'b1, 32'hffffff9c, 32'd7);
        drain();
        grant_q.push_back(1);
        push_rsp(1, 32'd0, 1'b1, 4'b0101);
        issue(1, 1'b0, 32'd15, 32'd0);
        drain();

        // Both requesters held valid from reset: grants alternate 0,1,0.
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        set_req(0, 1'b0, 32'd50, 32'd5);
        set_req(1, 1'b0, 32'd81, 32'd9);
        grant_q.push_back(0); push_rsp(0, 32'd10, 1'b0, 4'b0000);
        grant_q.push_back(1); push_rsp(1, 32'd9,  1'b0, 4'b0000);
        grant_q.push_back(0); push_rsp(0, 32'd10, 1'b0, 4'b0000);
        run_both(3);
        drain();

        // Response back-pressure: req1 must wait until the cycle after ready.
        rsp_ready = 2'b10;
        grant_q.push_back(0);
        push_rsp(0, 32'd20, 1'b0, 4'b0000);
        issue(0, 1'b0, 32'd200, 32'd10);
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (rsp_valid[0]) break;
        end
        check("hold_rsp_seen", 64'(rsp_valid), 64'b01);
        step();
        set_req(1, 1'b0, 32'd7, 32'd7);
        grant_q.push_back(1);
        push_rsp(1, 32'd1, 1'b0, 4'b0000);
        req_valid[1] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("hold_rsp_valid", 64'(rsp_valid), 64'b01);
            check("hold_quotient", 64'(rsp_quotient), 64'd20);
            check("hold_flags", 64'(rsp_flags), 64'd0);
            check("hold_no_grant", 64'(req_ready), 64'd0);
        end
        step();
        rsp_ready = 2'b11;
        @(negedge clk);
        check("no_grant_in_resp", 64'(req_ready), 64'd0);
        @(negedge clk);
        check("grant_after_resp", 64'(req_ready), 64'b10);
        step();
        req_valid[1] = 1'b0;
        drain();

        // Reset during WAIT abandons the transaction and rewinds the pointer.
        grant_q.push_back(0);
        issue(0, 1'b0, 32'd9, 32'd3);
        step();
        reset = 1'b1;
        step();
        @(negedge clk);
        check("wreset_rsp_valid", 64'(rsp_valid), 64'd0);
        check("wreset_div_wr", 64'(div_wr), 64'd0);
        check("wreset_owner", 64'(owner), 64'd0);
        check("wreset_div_num", 64'(div_numerator), 64'd0);
        check("wreset_quotient", 64'(rsp_quotient), 64'd0);
        check("wreset_req_ready", 64'(req_ready), 64'd0);
        step();
        reset = 1'b0;
        step();
        set_req(0, 1'b0, 32'd12, 32'd4);
        set_req(1, 1'b0, 32'd30, 32'd6);
        grant_q.push_back(0); push_rsp(0, 32'd3, 1'b0, 4'b0000);
        grant_q.push_back(1); push_rsp(1, 32'd5, 1'b0, 4'b0000);
        run_both(2);
        drain();

        // Spurious divider valid while idle.
        inject = 1'b1;
        step();
        inject = 1'b0;
        step();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("spur_protocol_err", 64'(protocol_err), 64'd1);
            check("spur_rsp_valid", 64'(rsp_valid), 64'd0);
        end
        step();
        grant_q.push_back(0);
        push_rsp(0, 32'd3, 1'b0, 4'b0000);
        issue(0, 1'b0, 32'd7, 32'd2);
        drain();
        @(negedge clk);
        check("spur_sticky", 64'(protocol_err), 64'd1);
        step();
        reset = 1'b1;
        step();
        @(negedge clk);
        check("spur_cleared", 64'(protocol_err), 64'd0);
        step();
        reset = 1'b0;
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
